// File: rtl/keypad_scanner.sv
`default_nettype none
// == keypad_scanner : 4x4 matrix keypad column scanner, debounce, valid/ack key output == Rev 1.0 ==
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  state_t           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             tick, accept, single_low;
  logic [3:0]       row_low;
  logic [1:0]       low_idx;

  assign tick    = (div_q == DIV_LAST);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign row_low = ~row_sync_q;
  // Two or more rows low at once is ghosting and never counts as a press.
  assign single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

  always_comb begin
    low_idx = 2'd0;
    case (row_low)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (single_low) begin
            row_idx_d = low_idx;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (single_low && (low_idx == row_idx_q)) begin
            if (cnt_inc == CNT_DONE) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          if (row_sync_q == 4'hF) begin
            if (cnt_inc == CNT_DONE) begin
              cnt_d     = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // An acked slot may be refilled in the same cycle; otherwise a new key is dropped.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (key_ack && valid_q) valid_d = 1'b0;
    if (accept) begin
      if (!valid_q || key_ack) begin
        code_d  = {low_idx, col_idx_q};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD);
  assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// == tb_keypad_scanner : directed vector bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3) == Rev 1.0 ==
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;
  logic [15:0] press;

  int cyc;
  int passed;
  int total;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  typedef struct {
    int          cyc;
    logic [15:0] press;
    logic        ack;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        valid;
    logic        held;
    logic        ovr;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t v(int c, logic [15:0] p, logic a, logic [3:0] cl,
                             logic [3:0] cd, logic vl, logic hd, logic ov);
    vec_t t;
    t.cyc = c; t.press = p; t.ack = a; t.col = cl;
    t.code = cd; t.valid = vl; t.held = hd; t.ovr = ov;
    return t;
  endfunction

  task automatic adv(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  initial begin
    reset = 1'b1; key_ack = 1'b0; press = 16'h0;
    cyc = 0; passed = 0; total = 0;

    //             cyc  press     ack  col      code  v     h     ovr
    tbl[0]  = v(  0, 16'h0000, 1'b0, 4'hE, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[1]  = v(  3, 16'h0000, 1'b0, 4'hE, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[2]  = v(  4, 16'h0000, 1'b0, 4'hD, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[3]  = v(  8, 16'h0040, 1'b0, 4'hB, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[4]  = v( 11, 16'h0040, 1'b0, 4'hB, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[5]  = v( 12, 16'h0040, 1'b0, 4'hB, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[6]  = v( 16, 16'h0040, 1'b0, 4'hB, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[7]  = v( 19, 16'h0040, 1'b0, 4'hB, 4'd0,  1'b0, 1'b0, 1'b0);
    tbl[8]  = v( 20, 16'h0040, 1'b0, 4'hB, 4'd6,  1'b1, 1'b1, 1'b0);
    tbl[9]  = v( 21, 16'h0040, 1'b1, 4'hB, 4'd6,  1'b1, 1'b1, 1'b0);
    tbl[10] = v( 22, 16'h0000, 1'b0, 4'hB, 4'd6,  1'b0, 1'b1, 1'b0);
    tbl[11] = v( 35, 16'h0000, 1'b0, 4'hB, 4'd6,  1'b0, 1'b1, 1'b0);
    tbl[12] = v( 36, 16'h0000, 1'b0, 4'h7, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[13] = v( 40, 16'h0001, 1'b0, 4'hE, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[14] = v( 44, 16'h0001, 1'b0, 4'hE, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[15] = v( 48, 16'h0000, 1'b0, 4'hE, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[16] = v( 52, 16'h0022, 1'b0, 4'hD, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[17] = v( 56, 16'h0022, 1'b0, 4'hB, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[18] = v( 64, 16'h0022, 1'b0, 4'hE, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[19] = v( 68, 16'h0022, 1'b0, 4'hD, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[20] = v( 72, 16'h0000, 1'b0, 4'hB, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[21] = v( 80, 16'h0001, 1'b0, 4'hE, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[22] = v( 91, 16'h0001, 1'b0, 4'hE, 4'd6,  1'b0, 1'b0, 1'b0);
    tbl[23] = v( 92, 16'h0000, 1'b0, 4'hE, 4'd0,  1'b1, 1'b1, 1'b0);
    tbl[24] = v(104, 16'h0000, 1'b0, 4'hD, 4'd0,  1'b1, 1'b0, 1'b0);
    tbl[25] = v(112, 16'h8000, 1'b0, 4'h7, 4'd0,  1'b1, 1'b0, 1'b0);
    tbl[26] = v(123, 16'h8000, 1'b0, 4'h7, 4'd0,  1'b1, 1'b0, 1'b0);
    tbl[27] = v(124, 16'h0000, 1'b0, 4'h7, 4'd0,  1'b1, 1'b1, 1'b1);
    tbl[28] = v(136, 16'h0000, 1'b0, 4'hE, 4'd0,  1'b1, 1'b0, 1'b1);
    tbl[29] = v(148, 16'h8000, 1'b0, 4'h7, 4'd0,  1'b1, 1'b0, 1'b1);
    tbl[30] = v(159, 16'h8000, 1'b1, 4'h7, 4'd0,  1'b1, 1'b0, 1'b1);
    tbl[31] = v(160, 16'h8000, 1'b0, 4'h7, 4'd15, 1'b1, 1'b1, 1'b1);

    adv(3);
    reset = 1'b0;
    cyc = 0;

    for (int i = 0; i < 32; i++) begin
      adv(tbl[i].cyc - cyc);
      chk($sformatf("v%0d_col", i),   col,              tbl[i].col);
      chk($sformatf("v%0d_code", i),  key_code,         tbl[i].code);
      chk($sformatf("v%0d_valid", i), {3'b0, key_valid}, {3'b0, tbl[i].valid});
      chk($sformatf("v%0d_held", i),  {3'b0, key_held},  {3'b0, tbl[i].held});
      chk($sformatf("v%0d_ovr", i),   {3'b0, overrun},   {3'b0, tbl[i].ovr});
      press   = tbl[i].press;
      key_ack = tbl[i].ack;
    end

    // Reset while HELD with a pending key and a sticky overrun.
    adv(2);
    reset = 1'b1;
    adv(1);
    chk("rst_col",   col,               4'hE);
    chk("rst_code",  key_code,          4'd0);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    chk("rst_held",  {3'b0, key_held},  4'd0);
    chk("rst_ovr",   {3'b0, overrun},   4'd0);
    reset = 1'b0;
    press = 16'h0;
    cyc = 0;
    adv(3);
    chk("rst_div_hold", col, 4'hE);
    adv(1);
    chk("rst_div_wrap", col, 4'hD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
